ex_mem_reg: RTL and testbench

//  EX->MEM pipeline register of the 5-stage CPU. Captures the execute stage's
//  GPR write-back request and HI/LO write request at the end of each cycle and

---
 rtl/ex_mem_reg_if.sv | 39 +++
 rtl/ex_mem_reg.sv | 115 +++++++++++
 tb/tb_ex_mem_reg.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_reg_if.sv
// EX/MEM boundary bundle: the EX-side request captured by the register and the
// MEM-side view it presents, plus the MADD/MSUB partial-product feedback path.
interface ex_mem_reg_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 2
);
    logic [RADDR_W-1:0]  ex_wd_i;
    logic                ex_wreg_i;
    logic [DATA_W-1:0]   ex_wdata_i;
    logic                ex_whilo_i;
    logic [DATA_W-1:0]   ex_hi_i;
    logic [DATA_W-1:0]   ex_lo_i;
    logic [2*DATA_W-1:0] hilo_temp_i;
    logic [CNT_W-1:0]    cnt_i;

    logic [RADDR_W-1:0]  mem_wd_o;
    logic                mem_wreg_o;
    logic [DATA_W-1:0]   mem_wdata_o;
    logic                mem_whilo_o;
    logic [DATA_W-1:0]   mem_hi_o;
    logic [DATA_W-1:0]   mem_lo_o;
    logic [2*DATA_W-1:0] hilo_temp_o;
    logic [CNT_W-1:0]    cnt_o;

    modport master (
        output ex_wd_i, ex_wreg_i, ex_wdata_i, ex_whilo_i, ex_hi_i, ex_lo_i,
               hilo_temp_i, cnt_i,
        input  mem_wd_o, mem_wreg_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o,
               hilo_temp_o, cnt_o
    );

    modport slave (
        input  ex_wd_i, ex_wreg_i, ex_wdata_i, ex_whilo_i, ex_hi_i, ex_lo_i,
               hilo_temp_i, cnt_i,
        output mem_wd_o, mem_wreg_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o,
               hilo_temp_o, cnt_o
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: forwards write-back/HI-LO requests, parks the
// MADD/MSUB partial product during EX stalls, and counts inserted bubbles.
module ex_mem_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_ex_i,
    input  logic              stall_mem_i,
    input  logic              flush_i,
    ex_mem_reg_if.slave       bus,
    output logic [PERF_W-1:0] bubble_cnt_o
);
    logic [RADDR_W-1:0]  wd_q,     wd_d;
    logic                wreg_q,   wreg_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic                whilo_q,  whilo_d;
    logic [DATA_W-1:0]   hi_q,     hi_d;
    logic [DATA_W-1:0]   lo_q,     lo_d;
    logic [2*DATA_W-1:0] htemp_q,  htemp_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [PERF_W-1:0]   bubble_q, bubble_d;

    logic bubble_c;
    logic advance_c;

    assign bubble_c  = stall_ex_i && !stall_mem_i;
    assign advance_c = !stall_ex_i && !stall_mem_i;

    // Next-state selection; flush beats everything, illegal advance+mem-stall holds.
    always_comb begin
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        whilo_d  = whilo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        htemp_d  = htemp_q;
        cnt_d    = cnt_q;
        bubble_d = bubble_q;
        if (flush_i) begin
            wd_d    = '0;
            wreg_d  = 1'b0;
            wdata_d = '0;
            whilo_d = 1'b0;
            hi_d    = '0;
            lo_d    = '0;
            htemp_d = '0;
            cnt_d   = '0;
        end else if (bubble_c) begin
            wd_d    = '0;
            wreg_d  = 1'b0;
            wdata_d = '0;
            whilo_d = 1'b0;
            hi_d    = '0;
            lo_d    = '0;
            htemp_d = bus.hilo_temp_i;
            cnt_d   = bus.cnt_i;
            if (bubble_q != {PERF_W{1'b1}}) begin
                bubble_d = bubble_q + PERF_W'(1);
            end
        end else if (advance_c) begin
            wd_d    = bus.ex_wd_i;
            wreg_d  = bus.ex_wreg_i;
            wdata_d = bus.ex_wdata_i;
            whilo_d = bus.ex_whilo_i;
            hi_d    = bus.ex_hi_i;
            lo_d    = bus.ex_lo_i;
            htemp_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            wdata_q  <= '0;
            whilo_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            htemp_q  <= '0;
            cnt_q    <= '0;
            bubble_q <= '0;
        end else begin
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            whilo_q  <= whilo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            htemp_q  <= htemp_d;
            cnt_q    <= cnt_d;
            bubble_q <= bubble_d;
        end
    end

    assign bus.mem_wd_o    = wd_q;
    assign bus.mem_wreg_o  = wreg_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_whilo_o = whilo_q;
    assign bus.mem_hi_o    = hi_q;
    assign bus.mem_lo_o    = lo_q;
    assign bus.hilo_temp_o = htemp_q;
    assign bus.cnt_o       = cnt_q;
    assign bubble_cnt_o    = bubble_q;

    // Stall only propagates upstream, so MEM stalled under a running EX is a control bug.
    a_no_mem_stall_alone : assert property (
        @(posedge clk) disable iff (!rst) !(stall_mem_i && !stall_ex_i && !flush_i)
    );
endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: expected register snapshots are queued when
// stimulus is driven and compared one cycle later, after the capturing edge.
module tb_ex_mem_reg;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned PERF_W  = 4;

    typedef struct packed {
        logic [RADDR_W-1:0]  wd;
        logic                wreg;
        logic [DATA_W-1:0]   wdata;
        logic                whilo;
        logic [DATA_W-1:0]   hi;
        logic [DATA_W-1:0]   lo;
        logic [2*DATA_W-1:0] ht;
        logic [CNT_W-1:0]    cnt;
        logic [PERF_W-1:0]   bub;
    } snap_t;

    logic clk, rst, stall_ex, stall_mem, flush;
    logic [PERF_W-1:0] bubble_cnt;

    ex_mem_reg_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) bus ();

    ex_mem_reg #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_ex_i   (stall_ex),
        .stall_mem_i  (stall_mem),
        .flush_i      (flush),
        .bus          (bus.slave),
        .bubble_cnt_o (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    snap_t sb[$];
    snap_t obs, exp_s;
    logic [PERF_W-1:0] exp_bub;

    function automatic snap_t mk(logic [RADDR_W-1:0] wd, logic wreg, logic [DATA_W-1:0] wdata,
                                 logic whilo, logic [DATA_W-1:0] hi, logic [DATA_W-1:0] lo,
                                 logic [2*DATA_W-1:0] ht, logic [CNT_W-1:0] cnt,
                                 logic [PERF_W-1:0] bub);
        snap_t s;
        s.wd = wd; s.wreg = wreg; s.wdata = wdata; s.whilo = whilo;
        s.hi = hi; s.lo = lo; s.ht = ht; s.cnt = cnt; s.bub = bub;
        return s;
    endfunction

    function automatic snap_t observe();
        return mk(bus.mem_wd_o, bus.mem_wreg_o, bus.mem_wdata_o, bus.mem_whilo_o,
                  bus.mem_hi_o, bus.mem_lo_o, bus.hilo_temp_o, bus.cnt_o, bubble_cnt);
    endfunction

    task automatic drive(logic fl, logic sex, logic smem, logic [RADDR_W-1:0] wd, logic wreg,
                         logic [DATA_W-1:0] wdata, logic whilo, logic [DATA_W-1:0] hi,
                         logic [DATA_W-1:0] lo, logic [2*DATA_W-1:0] ht, logic [CNT_W-1:0] cnt);
        flush = fl; stall_ex = sex; stall_mem = smem;
        bus.ex_wd_i = wd; bus.ex_wreg_i = wreg; bus.ex_wdata_i = wdata;
        bus.ex_whilo_i = whilo; bus.ex_hi_i = hi; bus.ex_lo_i = lo;
        bus.hilo_temp_i = ht; bus.cnt_i = cnt;
    endtask

    task automatic bump_bub();
        if (exp_bub != 4'hF) exp_bub = exp_bub + 4'd1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 64'd0, 2'd0);
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        exp_bub = '0;
        sb.push_back(mk('0, 0, '0, 0, '0, '0, '0, '0, '0));
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL reset_init: got %h exp %h", obs, exp_s); end
        @(negedge clk) rst = 1'b1;
        // First post-reset edge with idle ex_* inputs still reads all-zero.
        sb.push_back(mk('0, 0, '0, 0, '0, '0, '0, '0, '0));
        @(posedge clk); #1;
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL reset_idle: got %h exp %h", obs, exp_s); end
    endtask

    task automatic test_reset_midstream();
        drive(1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 32'h12345678, 1'b0, 32'd0, 32'd0, 64'd0, 2'd0);
        sb.push_back(mk(5'd3, 1, 32'h12345678, 0, '0, '0, '0, '0, exp_bub));
        @(posedge clk); #1;
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL midstream_load: got %h exp %h", obs, exp_s); end
        #2 rst = 1'b0;
        #1;
        exp_bub = '0;
        sb.push_back(mk('0, 0, '0, 0, '0, '0, '0, '0, '0));
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL midstream_async_reset: got %h exp %h", obs, exp_s); end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_advance();
        drive(1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b1, 32'd1, 32'd2, 64'hFFFF, 2'd3);
        sb.push_back(mk(5'd5, 1, 32'hDEADBEEF, 1, 32'd1, 32'd2, '0, '0, exp_bub));
        @(posedge clk); #1;
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL advance: got %h exp %h", obs, exp_s); end
    endtask

    task automatic test_madd_bubble();
        drive(1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 32'hAAAA5555, 1'b1, 32'd9, 32'd8,
              64'h0000000100000002, 2'd1);
        bump_bub();
        sb.push_back(mk('0, 0, '0, 0, '0, '0, 64'h0000000100000002, 2'd1, exp_bub));
        @(posedge clk); #1;
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL madd_bubble: got %h exp %h", obs, exp_s); end
        drive(1'b0, 1'b0, 1'b0, 5'd7, 1'b0, 32'h0BADF00D, 1'b1, 32'h11, 32'h22,
              64'h0000000300000004, 2'd2);
        sb.push_back(mk(5'd7, 0, 32'h0BADF00D, 1, 32'h11, 32'h22, '0, '0, exp_bub));
        @(posedge clk); #1;
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL madd_release: got %h exp %h", obs, exp_s); end
    endtask

    task automatic test_hold();
        test_advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 5'(i + 9), 1'b0, $urandom, 1'b0, $urandom, $urandom,
                  {$urandom, $urandom}, 2'(i));
            sb.push_back(mk(5'd5, 1, 32'hDEADBEEF, 1, 32'd1, 32'd2, '0, '0, exp_bub));
            @(posedge clk); #1;
            exp_s = sb.pop_front(); obs = observe(); n_tests++;
            if (obs !== exp_s) begin n_fail++; $display("FAIL hold_%0d: got %h exp %h", i, obs, exp_s); end
        end
        // Parked partial product must also survive a hold.
        drive(1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 32'd1, 1'b1, 32'd1, 32'd1, 64'hCAFE0000BEEF0000, 2'd2);
        bump_bub();
        sb.push_back(mk('0, 0, '0, 0, '0, '0, 64'hCAFE0000BEEF0000, 2'd2, exp_bub));
        @(posedge clk); #1;
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL hold_pre_bubble: got %h exp %h", obs, exp_s); end
        drive(1'b0, 1'b1, 1'b1, 5'd2, 1'b1, 32'd3, 1'b1, 32'd4, 32'd5, 64'h1, 2'd3);
        sb.push_back(mk('0, 0, '0, 0, '0, '0, 64'hCAFE0000BEEF0000, 2'd2, exp_bub));
        @(posedge clk); #1;
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL hold_partial: got %h exp %h", obs, exp_s); end
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 32'd6, 1'b1, 32'd7, 32'd8, 64'h123456789ABCDEF0, 2'd3);
        bump_bub();
        sb.push_back(mk('0, 0, '0, 0, '0, '0, 64'h123456789ABCDEF0, 2'd3, exp_bub));
        @(posedge clk); #1;
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL flush_setup: got %h exp %h", obs, exp_s); end
        drive(1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 32'd6, 1'b1, 32'd7, 32'd8, 64'h0FEDCBA987654321, 2'd1);
        sb.push_back(mk('0, 0, '0, 0, '0, '0, '0, '0, exp_bub));
        @(posedge clk); #1;
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL flush_over_bubble: got %h exp %h", obs, exp_s); end
        test_advance();
        drive(1'b1, 1'b0, 1'b0, 5'd30, 1'b1, 32'hFFFFFFFF, 1'b1, 32'd3, 32'd4, 64'd5, 2'd1);
        sb.push_back(mk('0, 0, '0, 0, '0, '0, '0, '0, exp_bub));
        @(posedge clk); #1;
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL flush_over_advance: got %h exp %h", obs, exp_s); end
        test_advance();
        drive(1'b1, 1'b1, 1'b1, 5'd30, 1'b1, 32'hFFFFFFFF, 1'b1, 32'd3, 32'd4, 64'd5, 2'd1);
        sb.push_back(mk('0, 0, '0, 0, '0, '0, '0, '0, exp_bub));
        @(posedge clk); #1;
        exp_s = sb.pop_front(); obs = observe(); n_tests++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL flush_over_hold: got %h exp %h", obs, exp_s); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            logic [RADDR_W-1:0] wd = 5'($urandom);
            logic wreg = 1'($urandom);
            logic [DATA_W-1:0] wdata = $urandom;
            logic whilo = 1'($urandom);
            logic [DATA_W-1:0] hi = $urandom;
            logic [DATA_W-1:0] lo = $urandom;
            drive(1'b0, 1'b0, 1'b0, wd, wreg, wdata, whilo, hi, lo, {$urandom, $urandom}, 2'($urandom));
            sb.push_back(mk(wd, wreg, wdata, whilo, hi, lo, '0, '0, exp_bub));
            @(posedge clk); #1;
            exp_s = sb.pop_front(); obs = observe(); n_tests++;
            if (obs !== exp_s) begin n_fail++; $display("FAIL b2b_%0d: got %h exp %h", i, obs, exp_s); end
        end
    endtask

    task automatic test_saturation();
        rst = 1'b0;
        #1 rst = 1'b1;
        exp_bub = '0;
        for (int i = 0; i < 20; i++) begin
            logic [2*DATA_W-1:0] ht = {$urandom, $urandom};
            logic [CNT_W-1:0] c = 2'($urandom);
            drive(1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 32'd1, 1'b1, 32'd1, 32'd1, ht, c);
            exp_bub = (i >= 14) ? 4'd15 : 4'(i + 1);
            sb.push_back(mk('0, 0, '0, 0, '0, '0, ht, c, exp_bub));
            @(posedge clk); #1;
            exp_s = sb.pop_front(); obs = observe(); n_tests++;
            if (obs !== exp_s) begin n_fail++; $display("FAIL saturate_%0d: got %h exp %h", i, obs, exp_s); end
        end
    endtask

    initial begin
        rst = 1'b1;
        exp_bub = '0;
        test_reset();
        test_reset_midstream();
        test_advance();
        test_madd_bubble();
        test_hold();
        test_flush();
        test_back_to_back();
        test_saturation();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 64'd0, 2'd0);
        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
